id_ex_stage: RTL

ID/EX pipeline register for the pipelined TSC CPU, directly downstream of the 4x16 register file.
- Captures the RF read operands together with decoded control, immediate and PC.
- Resolves data hazards by forwarding from EX, MEM and WB, and inserts a one-cycle bubble on load-use.
- Supports flush on branch/jump mispredict and hold on a downstream wait.
- Exposes a saturating stall counter for performance checks.

---
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register for the pipelined TSC CPU. Captures RF
//             operands with decoded control, forwards from EX/MEM/WB, inserts
//             a load-use bubble, supports flush/hold and counts stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    // decoded instruction from ID
    input  logic              id_valid,
    input  logic [1:0]        id_rs1,
    input  logic [1:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [1:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    // register file read data
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    // forwarding sources
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [1:0]        mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_write,
    input  logic [1:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    // pipeline control
    input  logic              flush,
    input  logic              hold,
    output logic              stall,
    // EX stage register outputs
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [1:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [15:0]       stall_count
);

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic              r_ex_valid;
    logic              r_ex_reg_write;
    logic              r_ex_mem_read;
    logic              r_ex_mem_write;
    logic [1:0]        r_ex_rd;
    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [DATA_W-1:0] r_ex_op1;
    logic [DATA_W-1:0] r_ex_op2;
    logic [DATA_W-1:0] r_ex_imm;
    logic [DATA_W-1:0] r_ex_pc;
    logic [15:0]       r_stall_count;

    // ------------------------------------------------------------------------
    // Combinational hazard / forwarding signals
    // ------------------------------------------------------------------------
    logic              w_ex_fwd_en;
    logic              w_mem_fwd_en;
    logic              w_load_use;
    logic              w_bubble;
    logic              w_stall;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    // Nearest-producer-first operand selection. A load in EX has no data yet,
    // so it is never a forwarding source; the load-use bubble covers it.
    function automatic logic [DATA_W-1:0] f_fwd(
        input logic [1:0]        rs,
        input logic [DATA_W-1:0] rf,
        input logic              ex_en,
        input logic [1:0]        ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              mem_en,
        input logic [1:0]        mem_dst,
        input logic [DATA_W-1:0] mem_val,
        input logic              wb_en,
        input logic [1:0]        wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] v;
        if (ex_en && (ex_dst == rs)) begin
            v = ex_val;
        end else if (mem_en && (mem_dst == rs)) begin
            v = mem_val;
        end else if (wb_en && (wb_dst == rs)) begin
            // RF write lands only at the edge, so rf data is stale this cycle
            v = wb_val;
        end else begin
            v = rf;
        end
        return v;
    endfunction

    // Forwarding enables for the EX and MEM producers
    always_comb begin
        w_ex_fwd_en  = r_ex_valid & r_ex_reg_write & ~r_ex_mem_read;
        w_mem_fwd_en = mem_valid & mem_reg_write;
    end

    // Forwarded operands for both source registers, selected independently
    always_comb begin
        w_op1 = f_fwd(id_rs1, rf_data1, w_ex_fwd_en, r_ex_rd, ex_result,
                      w_mem_fwd_en, mem_rd, mem_result,
                      wb_write, wb_addr, wb_data);
        w_op2 = f_fwd(id_rs2, rf_data2, w_ex_fwd_en, r_ex_rd, ex_result,
                      w_mem_fwd_en, mem_rd, mem_result,
                      wb_write, wb_addr, wb_data);
    end

    // Load-use detection and the upstream stall request
    always_comb begin
        w_load_use = id_valid & r_ex_valid & r_ex_mem_read & r_ex_reg_write &
                     ((id_use_rs1 & (r_ex_rd == id_rs1)) |
                      (id_use_rs2 & (r_ex_rd == id_rs2)));
        // flush kills the ID instruction, so there is nothing to retry
        w_stall    = hold | (w_load_use & ~flush);
        // both flush and load-use leave an empty slot in EX
        w_bubble   = flush | w_load_use;
    end

    // EX register update: hold > flush > load-use bubble > capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_mem_write <= 1'b0;
            r_ex_rd        <= '0;
            r_ex_ctrl      <= '0;
            r_ex_op1       <= '0;
            r_ex_op2       <= '0;
            r_ex_imm       <= '0;
            r_ex_pc        <= '0;
        end else if (!hold) begin
            // data fields are don't-care on a bubble; capturing keeps the mux small
            r_ex_rd        <= id_rd;
            r_ex_ctrl      <= id_ctrl & {CTRL_W{id_valid}};
            r_ex_op1       <= w_op1;
            r_ex_op2       <= w_op2;
            r_ex_imm       <= id_imm;
            r_ex_pc        <= id_pc;
            if (w_bubble) begin
                r_ex_valid     <= 1'b0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_mem_write <= 1'b0;
            end else begin
                r_ex_valid     <= id_valid;
                r_ex_reg_write <= id_reg_write & id_valid;
                r_ex_mem_read  <= id_mem_read & id_valid;
                r_ex_mem_write <= id_mem_write & id_valid;
            end
        end
    end

    // Saturating count of cycles in which the stage requested a stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign stall        = w_stall;
    assign ex_valid     = r_ex_valid;
    assign ex_reg_write = r_ex_reg_write;
    assign ex_mem_read  = r_ex_mem_read;
    assign ex_mem_write = r_ex_mem_write;
    assign ex_rd        = r_ex_rd;
    assign ex_ctrl      = r_ex_ctrl;
    assign ex_op1       = r_ex_op1;
    assign ex_op2       = r_ex_op2;
    assign ex_imm       = r_ex_imm;
    assign ex_pc        = r_ex_pc;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire
